dlist_dma: RTL and testbench
============================

DLIST_DMA -- requirements
Module: dlist_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: address width of pointer, MSR and memory bus.
REQ-002 SHALL have parameter WRAP_W, default 10: number of low pointer bits that increment; bits above are held.
REQ-003 SHALL have parameter LCNT_W, default 5: width of the scanline counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 phi2  in  1  system clock, rising-edge active.
REQ-006 rst_L  in  1  asynchronous active-low reset.
REQ-007 start  in  1  pulse that loads the pointer from dlist_base and begins fetching.
REQ-008 dlist_base  in  ADDR_W  display-list start address (DLISTH:DLISTL).
REQ-009 dma_en  in  1  DMACTL display-list DMA enable.
REQ-010 line_done  in  1  end-of-scanline pulse.
REQ-011 vblank  in  1  vertical-blank start pulse.
REQ-012 mem_req/mem_addr  out  1/ADDR_W  memory read request and address; mem_ack/mem_data  in  1/8  read acknowledge and read data.
REQ-013 halt_L  out  1  CPU halt, equal to ~mem_req.
REQ-014 ir/ir_valid  out  8/1  current instruction and a 1-cycle load pulse.
REQ-015 msr/msr_load  out  ADDR_W/1  memory scan address and a 1-cycle update pulse.
REQ-016 mode/dli/dlist_ptr/state  out  4/1/ADDR_W/3  current mode, DLI pulse, pointer, and FSM state (debug).

Function
REQ-017 FSM states: IDLE, FETCH_IR, FETCH_LO, FETCH_HI, LINES, WAIT_VB.
REQ-018 Memory handshake:
- mem_req is held with a stable mem_addr until the cycle in which mem_ack=1.
- Data is captured in that cycle.
- mem_req deasserts the following cycle.
- Zero-wait minimum: 2 cycles per byte.
REQ-019 Pointer increment: each fetched byte increments dlist_ptr[WRAP_W-1:0] modulo 2^WRAP_W; dlist_ptr[ADDR_W-1:WRAP_W] is unchanged.
REQ-020 In FETCH_IR, a captured byte is written to ir, ir_valid pulses, and mode=ir[3:0].
REQ-021 ir[3:0]=0 (blank): go to LINES with count ir[6:4]+1.
REQ-022 ir[3:0]=1 (jump): fetch LO then HI, then load dlist_ptr={HI,LO}.
- If ir[6]=1 (JVB), go to WAIT_VB.
- Otherwise, go to FETCH_IR.
REQ-023 ir[3:0]>=2 with ir[6]=1 (LMS): fetch LO then HI, load msr={HI,LO}, pulse msr_load, then go to LINES.
REQ-024 ir[3:0]>=2 with ir[6]=0: go directly to LINES.
REQ-025 Lines per mode 2..F: 8,10,8,16,8,16,8,4,4,2,1,2,1,1.
REQ-026 In LINES, each line_done decrements the count; at count 0, go to FETCH_IR.
REQ-027 A line_done that arrives outside LINES (while active) is held in a single pending flag and consumed on entering LINES; further line_done pulses while pending are dropped.
REQ-028 dli pulses for 1 cycle with the final line_done of an instruction whose ir[7]=1.
REQ-029 WAIT_VB exits to FETCH_IR on vblank; vblank in any other state is ignored.
REQ-030 When dma_en=0, the FSM goes to IDLE at the next FETCH_IR entry or from WAIT_VB; an in-flight handshake always completes first.
REQ-031 start during an active fetch: the outstanding handshake completes, dlist_ptr reloads from dlist_base, and the FSM goes to FETCH_IR.
REQ-032 start with dma_en=0 loads the pointer only and stays in IDLE.
REQ-033 start coincident with mem_ack: the captured byte is discarded and the reload wins.

Reset
REQ-034 With rst_L=0, the block SHALL immediately set:
- state=IDLE
- mem_req=0, halt_L=1, mem_addr=0
- ir=0, ir_valid=0, mode=0
- msr=0, msr_load=0
- dlist_ptr=0, dli=0
- line counter and pending flag cleared.
REQ-035 Reset asserted mid-handshake SHALL abandon the request; there is no resumption after release.

Configuration
REQ-036 Macro DLIST_DLI_EN: when defined, dli SHALL behave per REQ-028; when undefined, dli SHALL be tied to 0 and ir[7] SHALL be ignored (ir still shows the byte).

Structure
REQ-037 Package dlist_pkg SHALL hold the state enum, the opcode field constants (BLANK=0, JUMP=1, LMS bit 6, DLI bit 7), and the mode-to-lines function.
REQ-038 Sub-module dlist_line_counter SHALL hold the load/decrement counter, the pending-line flag and the zero flag.

Verification
REQ-039 Reset, dlist_base=A000, dma_en=1, start; memory [A000]=70 -> mem_addr=A000, ir=70, LINES count 8, no msr_load.
REQ-040 [A000]=42,00,40 -> msr=4000 with one msr_load pulse, mode=2, 8 line_done pulses, then fetch at A003.
REQ-041 dlist_ptr=A3FF fetching opcode 02 -> next fetch address A000 (wrap inside the 1K block, upper bits kept).
REQ-042 [A000]=41,00,A0 -> WAIT_VB, no mem_req until vblank, then fetch at A000.
REQ-043 Opcode 82 with DLIST_DLI_EN defined -> dli pulses on the 8th line_done; with the macro undefined -> dli stays 0.
REQ-044 rst_L low while mem_req=1 with mem_ack held 0 -> mem_req=0 and halt_L=1 immediately; after release, no request until start.

Source files
------------

// File: rtl/dlist_pkg.sv
// Shared definitions for the display-list DMA engine:
// FSM state encoding, opcode field constants, mode-to-scanline lookup.
package dlist_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LINES_W = 5;

    localparam logic [3:0]  OP_BLANK = 4'h0;
    localparam logic [3:0]  OP_JUMP  = 4'h1;
    localparam int unsigned LMS_BIT  = 6;
    localparam int unsigned DLI_BIT  = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_IR = 3'd1,
        ST_FETCH_LO = 3'd2,
        ST_FETCH_HI = 3'd3,
        ST_LINES    = 3'd4,
        ST_WAIT_VB  = 3'd5
    } dlist_state_t;

    // Scanlines occupied by one instruction; blank lines come from op[6:4].
    function automatic logic [LINES_W-1:0] lines_for(input logic [7:0] op);
        logic [LINES_W-1:0] n;
        n = LINES_W'(1);
        case (op[3:0])
            4'h0:                   n = LINES_W'(op[6:4]) + LINES_W'(1);
            4'h2, 4'h4, 4'h6, 4'h8: n = LINES_W'(8);
            4'h3:                   n = LINES_W'(10);
            4'h5, 4'h7:             n = LINES_W'(16);
            4'h9, 4'hA:             n = LINES_W'(4);
            4'hB, 4'hD:             n = LINES_W'(2);
            default:                n = LINES_W'(1);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dlist_line_counter.sv
// Scanline counter for one display-list instruction.
// Ports: clk/rst_n; active (FSM not idle); in_lines (FSM in LINES);
// load/load_val (start a new instruction); line_done (scanline pulse);
// last_c (final line consumed this cycle), zero_c (count empty), pending
// (one line_done seen outside LINES, consumed once LINES is entered).
module dlist_line_counter #(
    parameter int unsigned LCNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              in_lines,
    input  logic              load,
    input  logic [LCNT_W-1:0] load_val,
    input  logic              line_done,
    output logic              last_c,
    output logic              zero_c,
    output logic              pending
);

    logic [LCNT_W-1:0] cnt_q;
    logic              evt_c;

    assign zero_c = (cnt_q == '0);
    // A held line counts exactly like a live one inside LINES.
    assign evt_c  = in_lines && (line_done || pending) && !zero_c;
    assign last_c = evt_c && (cnt_q == LCNT_W'(1));

    // Count register and single-deep pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pending <= 1'b0;
        end else begin
            if (load)
                cnt_q <= load_val;
            else if (evt_c)
                cnt_q <= cnt_q - LCNT_W'(1);

            if (!active)
                pending <= 1'b0;
            else if (in_lines)
                pending <= pending && line_done;  // a coincident live pulse re-arms it
            else if (line_done)
                pending <= 1'b1;                  // extra pulses collapse into one
        end
    end

endmodule

// File: rtl/dlist_dma.sv
// Display-list DMA: fetches display-list instructions over a byte-wide
// request/acknowledge bus, decodes blank/jump/LMS/mode opcodes and paces
// them against scanline and vertical-blank pulses.
// Ports: phi2/rst_L clock and async reset; start/dlist_base restart the list;
// dma_en enable; line_done/vblank timing; mem_req/mem_addr/mem_ack/mem_data
// memory bus; halt_L = ~mem_req; ir/ir_valid instruction; msr/msr_load scan
// address; mode, dli, dlist_ptr, state for display logic and debug.
// Build option: define DLIST_DLI_EN to generate dli from opcode bit 7.
module dlist_dma
    import dlist_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WRAP_W = 10,
    parameter int unsigned LCNT_W = 5
) (
    input  logic              phi2,
    input  logic              rst_L,
    input  logic              start,
    input  logic [ADDR_W-1:0] dlist_base,
    input  logic              dma_en,
    input  logic              line_done,
    input  logic              vblank,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              halt_L,
    output logic [7:0]        ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] msr,
    output logic              msr_load,
    output logic [3:0]        mode,
    output logic              dli,
    output logic [ADDR_W-1:0] dlist_ptr,
    output logic [2:0]        state
);

    dlist_state_t      state_q, state_d;
    logic              mem_req_d, halt_d, ir_valid_d, msr_load_d, dli_d;
    logic [ADDR_W-1:0] mem_addr_d, msr_d, ptr_d, ptr_inc;
    logic [7:0]        ir_d, lo_q, lo_d, load_op;
    logic [3:0]        mode_d;
    logic              restart_q, restart_d;
    logic              is_fetch, take, restart_fire, cnt_load;
    logic              last_c, zero_c, line_pend;
    dlist_state_t      entry;
    logic [LCNT_W-1:0] load_val;

    assign state    = state_q;
    assign is_fetch = (state_q == ST_FETCH_IR) || (state_q == ST_FETCH_LO) ||
                      (state_q == ST_FETCH_HI);
    // Entering FETCH_IR is where a cleared dma_en takes effect.
    assign entry    = dma_en ? ST_FETCH_IR : ST_IDLE;
    // A restart waits for any outstanding handshake; the byte it returns is dropped.
    assign restart_fire = (state_q != ST_IDLE) && (start || restart_q) &&
                          (!mem_req || mem_ack);
    assign take     = mem_req && mem_ack && !start && !restart_q;

    assign cnt_load = (state_d == ST_LINES) && (state_q != ST_LINES);
    assign load_op  = (state_q == ST_FETCH_IR) ? mem_data : ir;
    assign load_val = LCNT_W'(lines_for(load_op));

    dlist_line_counter #(.LCNT_W(LCNT_W)) u_line_counter (
        .clk       (phi2),
        .rst_n     (rst_L),
        .active    (state_q != ST_IDLE),
        .in_lines  (state_q == ST_LINES),
        .load      (cnt_load),
        .load_val  (load_val),
        .line_done (line_done),
        .last_c    (last_c),
        .zero_c    (zero_c),
        .pending   (line_pend)
    );

    // State and datapath registers.
    always_ff @(posedge phi2 or negedge rst_L) begin
        if (!rst_L) begin
            state_q   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            halt_L    <= 1'b1;
            ir        <= '0;
            ir_valid  <= 1'b0;
            mode      <= '0;
            msr       <= '0;
            msr_load  <= 1'b0;
            dlist_ptr <= '0;
            dli       <= 1'b0;
            lo_q      <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            halt_L    <= halt_d;
            ir        <= ir_d;
            ir_valid  <= ir_valid_d;
            mode      <= mode_d;
            msr       <= msr_d;
            msr_load  <= msr_load_d;
            dlist_ptr <= ptr_d;
            dli       <= dli_d;
            lo_q      <= lo_d;
            restart_q <= restart_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && dma_en)
                    state_d = ST_FETCH_IR;
            end
            ST_FETCH_IR: begin
                if (take) begin
                    if (mem_data[3:0] == OP_BLANK)
                        state_d = ST_LINES;
                    else if ((mem_data[3:0] == OP_JUMP) || mem_data[LMS_BIT])
                        state_d = ST_FETCH_LO;
                    else
                        state_d = ST_LINES;
                end
            end
            ST_FETCH_LO: begin
                if (take)
                    state_d = ST_FETCH_HI;
            end
            ST_FETCH_HI: begin
                if (take) begin
                    if (ir[3:0] == OP_JUMP)
                        state_d = ir[LMS_BIT] ? ST_WAIT_VB : entry;
                    else
                        state_d = ST_LINES;
                end
            end
            ST_LINES: begin
                if (last_c || zero_c)
                    state_d = entry;
            end
            ST_WAIT_VB: begin
                if (!dma_en)
                    state_d = ST_IDLE;
                else if (vblank)
                    state_d = ST_FETCH_IR;
            end
            default: state_d = ST_IDLE;
        endcase
        if (restart_fire)
            state_d = entry;
    end

    // Output and datapath next values.
    always_comb begin
        mem_req_d  = mem_req;
        mem_addr_d = mem_addr;
        ir_d       = ir;
        ir_valid_d = 1'b0;
        mode_d     = mode;
        msr_d      = msr;
        msr_load_d = 1'b0;
        ptr_d      = dlist_ptr;
        lo_d       = lo_q;
        dli_d      = 1'b0;
        restart_d  = restart_q;

        ptr_inc                = dlist_ptr;
        ptr_inc[WRAP_W-1:0]    = dlist_ptr[WRAP_W-1:0] + WRAP_W'(1);

        // Request held until acknowledged, then dropped for one cycle.
        if (mem_req) begin
            mem_req_d = !mem_ack;
        end else if (is_fetch && !start && !restart_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = dlist_ptr;
        end

        if ((state_q != ST_IDLE) && start && mem_req && !mem_ack)
            restart_d = 1'b1;
        if (restart_fire)
            restart_d = 1'b0;

        if ((start && (state_q == ST_IDLE)) || restart_fire) begin
            ptr_d = dlist_base;
        end else if (take) begin
            ptr_d = ptr_inc;
            case (state_q)
                ST_FETCH_IR: begin
                    ir_d       = mem_data;
                    ir_valid_d = 1'b1;
                    mode_d     = mem_data[3:0];
                end
                ST_FETCH_LO: lo_d = mem_data;
                ST_FETCH_HI: begin
                    if (ir[3:0] == OP_JUMP) begin
                        ptr_d = ADDR_W'({mem_data, lo_q});
                    end else begin
                        msr_d      = ADDR_W'({mem_data, lo_q});
                        msr_load_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

`ifdef DLIST_DLI_EN
        dli_d = last_c && ir[DLI_BIT];
`endif

        halt_d = !mem_req_d;
    end

endmodule

// File: tb/tb_dlist_dma.sv
// Directed bench for dlist_dma with a zero-wait byte memory model.
module tb_dlist_dma;

    localparam logic [2:0] S_IDLE = 3'd0, S_FIR = 3'd1, S_LINES = 3'd4, S_WVB = 3'd5;
`ifdef DLIST_DLI_EN
    localparam int DLI_EXP = 1, DLI_LINE_EXP = 8;
`else
    localparam int DLI_EXP = 0, DLI_LINE_EXP = 0;
`endif

    logic        phi2, rst_L, start, dma_en, line_done, vblank;
    logic [15:0] dlist_base, mem_addr, msr, dlist_ptr;
    logic        mem_req, mem_ack, halt_L, ir_valid, msr_load, dli;
    logic [7:0]  mem_data, ir;
    logic [3:0]  mode;
    logic [2:0]  state;
    logic        ack_en;
    logic [7:0]  mem [0:65535];

    int n_vec, n_err, cyc;
    logic [15:0] fetch_q[$];
    int fetch_t[$];
    int req_cyc, ir_valid_cnt, msr_cnt, dli_cnt, dli_line, lines_sent;

    assign mem_ack  = mem_req && ack_en;
    assign mem_data = mem[mem_addr];

    dlist_dma dut (
        .phi2(phi2), .rst_L(rst_L), .start(start), .dlist_base(dlist_base),
        .dma_en(dma_en), .line_done(line_done), .vblank(vblank),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .halt_L(halt_L), .ir(ir), .ir_valid(ir_valid), .msr(msr), .msr_load(msr_load),
        .mode(mode), .dli(dli), .dlist_ptr(dlist_ptr), .state(state)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    always @(posedge phi2) cyc <= cyc + 1;

    // Bus and pulse observer, sampled mid-cycle.
    always @(negedge phi2) begin
        if (mem_req) req_cyc <= req_cyc + 1;
        if (mem_req && mem_ack) begin
            fetch_q.push_back(mem_addr);
            fetch_t.push_back(cyc);
        end
        if (ir_valid) ir_valid_cnt <= ir_valid_cnt + 1;
        if (msr_load) msr_cnt <= msr_cnt + 1;
        if (dli) begin
            dli_cnt  <= dli_cnt + 1;
            dli_line <= lines_sent;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge phi2);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_L = 1'b0; start = 0; line_done = 0; vblank = 0; ack_en = 1;
        #1;
        check({tag, "_rst_state"}, state, S_IDLE);
        check({tag, "_rst_req"}, mem_req, 0);
        check({tag, "_rst_halt"}, halt_L, 1);
        check({tag, "_rst_outs"}, {mem_addr, ir, msr, dlist_ptr, mode, dli, ir_valid, msr_load},
              0);
        step();
        fetch_q.delete(); fetch_t.delete();
        req_cyc = 0; ir_valid_cnt = 0; msr_cnt = 0; dli_cnt = 0; dli_line = 0; lines_sent = 0;
        rst_L = 1'b1;
        step();
    endtask

    task automatic do_start(input logic [15:0] base);
        dlist_base = base; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_line();
        line_done = 1'b1;
        step();
        line_done = 1'b0;
        lines_sent++;
        step();
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state !== s && n < 200) begin step(); n++; end
        check(tag, state, s);
        step();
    endtask

    task automatic wait_fetch(input int cnt, input string tag);
        int n = 0;
        while (fetch_q.size() < cnt && n < 200) begin step(); n++; end
        check(tag, fetch_q.size(), cnt);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 200) begin step(); n++; end
        check(tag, mem_req, 1);
    endtask

    initial begin
        int r0;
        n_vec = 0; n_err = 0; cyc = 0;
        rst_L = 1'b1; start = 0; dma_en = 1; line_done = 0; vblank = 0; ack_en = 1;
        dlist_base = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        #3;

        // Blank 8 lines
        mem[16'hA000] = 8'h70;
        do_reset("t1");
        do_start(16'hA000);
        wait_state(S_LINES, "t1_lines");
        check("t1_addr", fetch_q[0], 16'hA000);
        check("t1_ir", ir, 8'h70);
        check("t1_mode", mode, 0);
        check("t1_irv", ir_valid_cnt, 1);
        check("t1_msrl", msr_cnt, 0);
        for (int i = 0; i < 3; i++) send_line();
        vblank = 1'b1; step(); vblank = 1'b0; step();
        check("t1_vb_ignored", state, S_LINES);
        for (int i = 0; i < 4; i++) send_line();
        check("t1_7lines", state, S_LINES);
        send_line();
        wait_fetch(2, "t1_next");
        check("t1_next_addr", fetch_q[1], 16'hA001);

        // LMS mode 2
        mem[16'hA000] = 8'h42; mem[16'hA001] = 8'h00; mem[16'hA002] = 8'h40;
        do_reset("t2");
        do_start(16'hA000);
        wait_state(S_LINES, "t2_lines");
        check("t2_msr", msr, 16'h4000);
        check("t2_msrl", msr_cnt, 1);
        check("t2_mode", mode, 2);
        check("t2_nfetch", fetch_q.size(), 3);
        check("t2_a1", fetch_q[1], 16'hA001);
        check("t2_a2", fetch_q[2], 16'hA002);
        check("t2_byte_cyc", fetch_t[1] - fetch_t[0], 2);
        for (int i = 0; i < 7; i++) send_line();
        check("t2_7lines", state, S_LINES);
        send_line();
        wait_fetch(4, "t2_next");
        check("t2_next_addr", fetch_q[3], 16'hA003);

        // Pointer wrap inside 1K block
        mem[16'hA3FF] = 8'h02;
        do_reset("t3");
        do_start(16'hA3FF);
        wait_state(S_LINES, "t3_lines");
        check("t3_ptr", dlist_ptr, 16'hA000);
        for (int i = 0; i < 8; i++) send_line();
        wait_fetch(2, "t3_next");
        check("t3_next_addr", fetch_q[1], 16'hA000);

        // Jump and wait for vertical blank
        mem[16'hA000] = 8'h41; mem[16'hA001] = 8'h00; mem[16'hA002] = 8'hA0;
        do_reset("t4");
        do_start(16'hA000);
        wait_state(S_WVB, "t4_wvb");
        check("t4_ptr", dlist_ptr, 16'hA000);
        r0 = req_cyc;
        for (int i = 0; i < 20; i++) step();
        check("t4_noreq", req_cyc - r0, 0);
        check("t4_still_wvb", state, S_WVB);
        vblank = 1'b1; step(); vblank = 1'b0;
        wait_fetch(4, "t4_after_vb");
        check("t4_vb_addr", fetch_q[3], 16'hA000);

        // Display list interrupt on last line
        mem[16'hC000] = 8'h82;
        do_reset("t5");
        do_start(16'hC000);
        wait_state(S_LINES, "t5_lines");
        for (int i = 0; i < 7; i++) send_line();
        check("t5_dli_early", dli_cnt, 0);
        send_line();
        step();
        check("t5_dli_cnt", dli_cnt, DLI_EXP);
        check("t5_dli_line", dli_line, DLI_LINE_EXP);

        // Pending line during fetch, duplicate dropped; dma_en off at exit
        mem[16'hB000] = 8'h02;
        do_reset("t6");
        dlist_base = 16'hB000; start = 1'b1; step(); start = 1'b0;
        line_done = 1'b1; step(); step(); line_done = 1'b0;
        for (int i = 0; i < 6; i++) send_line();
        check("t6_6lines", state, S_LINES);
        dma_en = 1'b0;
        send_line();
        check("t6_idle", state, S_IDLE);
        for (int i = 0; i < 10; i++) step();
        check("t6_nofetch", fetch_q.size(), 1);
        dma_en = 1'b1;

        // Reset mid-handshake
        do_reset("t7");
        ack_en = 1'b0;
        do_start(16'hA000);
        wait_req("t7_req");
        check("t7_halt", halt_L, 0);
        rst_L = 1'b0;
        #1;
        check("t7_req_drop", mem_req, 0);
        check("t7_halt_rel", halt_L, 1);
        check("t7_state", state, S_IDLE);
        step(); rst_L = 1'b1; ack_en = 1'b1;
        r0 = req_cyc;
        for (int i = 0; i < 10; i++) step();
        check("t7_noresume", req_cyc - r0, 0);

        // Start with DMA disabled loads pointer only
        do_reset("t8");
        dma_en = 1'b0;
        do_start(16'h1234);
        check("t8_ptr", dlist_ptr, 16'h1234);
        for (int i = 0; i < 5; i++) step();
        check("t8_state", state, S_IDLE);
        check("t8_noreq", req_cyc, 0);
        dma_en = 1'b1;

        // Restart during stalled fetch
        mem[16'hA000] = 8'h42; mem[16'hD000] = 8'h70;
        do_reset("t9");
        ack_en = 1'b0;
        do_start(16'hA000);
        wait_req("t9_req");
        do_start(16'hD000);
        for (int i = 0; i < 3; i++) step();
        check("t9_held", mem_req, 1);
        check("t9_addr_stable", mem_addr, 16'hA000);
        ack_en = 1'b1;
        wait_state(S_LINES, "t9_lines");
        check("t9_reload", fetch_q[1], 16'hD000);
        check("t9_ir", ir, 8'h70);
        check("t9_irv", ir_valid_cnt, 1);

        // Restart coincident with acknowledge
        do_reset("t10");
        do_start(16'hA000);
        wait_req("t10_req");
        do_start(16'hD000);
        wait_state(S_LINES, "t10_lines");
        check("t10_reload", fetch_q[1], 16'hD000);
        check("t10_ir", ir, 8'h70);
        check("t10_irv", ir_valid_cnt, 1);
        check("t10_msrl", msr_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
